// File: rtl/z80_bus_timing_gen.sv
// Z80 bus timing generator: CPU clock-enable divider plus
// memory/IO wait-state insertion driven by bus strobe edges.
module z80_bus_timing_gen #(
  parameter int DIVW  = 3,
  parameter int WAITW = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIVW-1:0]  div_sel,
  input  logic [WAITW-1:0] mem_waits,
  input  logic [WAITW-1:0] io_waits,
  input  logic             mreq_n,
  input  logic             iorq_n,
  input  logic             m1_n,
  input  logic             rfsh_n,
  input  logic             ext_wait_n,
  output logic             clk_enable,
  output logic             wait_n,
  output logic             wait_active
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t           state;
  logic [DIVW-1:0]  cnt;
  logic [DIVW-1:0]  div_q;
  logic [WAITW-1:0] wcnt;
  logic             wait_int;
  logic             mreq_q;
  logic             iorq_q;
  logic             armed;
  logic             wrap;
  logic             mem_start;
  logic             io_start;

  assign wrap = (cnt == div_q);

  // The first enabled sample after reset only primes the edge
  // detector, so a strobe already low is not seen as a new fall.
  assign mem_start = armed & mreq_q & ~mreq_n & rfsh_n;
  assign io_start  = armed & iorq_q & ~iorq_n & m1_n;

  assign wait_n = wait_int & ext_wait_n;

  // Divider; ratio only reloads at the wrap so periods stay whole.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      div_q      <= div_sel;
      clk_enable <= 1'b0;
    end else begin
      clk_enable <= wrap;
      if (wrap) begin
        cnt   <= '0;
        div_q <= div_sel;
      end else begin
        cnt <= cnt + DIVW'(1);
      end
    end
  end

  // Strobe samples taken only on enabled CPU cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      mreq_q <= 1'b1;
      iorq_q <= 1'b1;
      armed  <= 1'b0;
    end else if (clk_enable) begin
      mreq_q <= mreq_n;
      iorq_q <= iorq_n;
      armed  <= 1'b1;
    end
  end

  // Wait-state FSM, advanced once per enabled CPU cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      wcnt        <= '0;
      wait_int    <= 1'b1;
      wait_active <= 1'b0;
    end else if (clk_enable) begin
      unique case (state)
        S_IDLE: begin
          if (mem_start) begin
            if (mem_waits != '0) begin
              state       <= S_WAIT;
              wcnt        <= mem_waits;
              wait_int    <= 1'b0;
              wait_active <= 1'b1;
            end else begin
              state <= S_HOLD;
            end
          end else if (io_start) begin
            if (io_waits != '0) begin
              state       <= S_WAIT;
              wcnt        <= io_waits;
              wait_int    <= 1'b0;
              wait_active <= 1'b1;
            end else begin
              state <= S_HOLD;
            end
          end
        end
        S_WAIT: begin
          if (wcnt == WAITW'(1)) begin
            state       <= S_HOLD;
            wcnt        <= '0;
            wait_int    <= 1'b1;
            wait_active <= 1'b0;
          end else begin
            wcnt <= wcnt - WAITW'(1);
          end
        end
        S_HOLD: begin
          if (mreq_n & iorq_n) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
